// File: rtl/decrypted_msg_checker.sv
// Reads back the decrypted bytes from the output RAM and decides whether
// the candidate key produced plaintext (lowercase letters and spaces only).
module decrypted_msg_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_chk,
    input  logic [7:0]        chk_q,
    output logic [ADDR_W-1:0] chk_address,
    output logic              busy,
    output logic              finish_chk,
    output logic              key_valid,
    output logic              key_invalid,
    output logic [ADDR_W-1:0] bad_index,
    output logic [7:0]        bad_byte
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CHECK,
        DONE
    } state_t;

    // Compared at ADDR_W width so a full-depth message ends at all-ones.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

    state_t state, state_n;
    logic   byte_ok;
    logic   clr;
    logic   inc;
    logic   set_valid;
    logic   set_bad;

    assign byte_ok = (chk_q == 8'h20) ||
                     ((chk_q >= 8'h61) && (chk_q <= 8'h7A));

    always_comb begin
        state_n    = state;
        clr        = 1'b0;
        inc        = 1'b0;
        set_valid  = 1'b0;
        set_bad    = 1'b0;
        busy       = (state != IDLE);
        finish_chk = (state == DONE);
        unique case (state)
            IDLE: begin
                if (start_chk) begin
                    clr     = 1'b1;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                state_n = CHECK;
            end
            CHECK: begin
                if (!byte_ok) begin
                    set_bad = 1'b1;
                    state_n = DONE;
                end else if (chk_address == LAST) begin
                    set_valid = 1'b1;
                    state_n   = DONE;
                end else begin
                    inc     = 1'b1;
                    state_n = ADDR;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_address <= '0;
            key_valid   <= 1'b0;
            key_invalid <= 1'b0;
            bad_index   <= '0;
            bad_byte    <= '0;
        end else begin
            if (clr) begin
                chk_address <= '0;
                key_valid   <= 1'b0;
                key_invalid <= 1'b0;
                bad_index   <= '0;
                bad_byte    <= '0;
            end
            if (inc) begin
                chk_address <= chk_address + 1'b1;
            end
            if (set_valid) begin
                key_valid <= 1'b1;
            end
            if (set_bad) begin
                key_invalid <= 1'b1;
                bad_index   <= chk_address;
                bad_byte    <= chk_q;
            end
        end
    end

endmodule

// File: tb/tb_decrypted_msg_checker.sv
// Bench for decrypted_msg_checker: a 32-byte and a 256-byte instance share
// one RAM image; an outcome-level model is compared on every cycle.
module tb_decrypted_msg_checker;

    logic       clk;
    logic       reset;
    logic       start_s;
    logic       start_b;
    logic [7:0] q_s;
    logic [7:0] q_b;
    logic [7:0] addr_s;
    logic [7:0] addr_b;
    logic       busy_s, busy_b;
    logic       fin_s, fin_b;
    logic       kv_s, kv_b;
    logic       ki_s, ki_b;
    logic [7:0] bi_s, bi_b;
    logic [7:0] bb_s, bb_b;

    logic [7:0] ram [256];

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    decrypted_msg_checker #(.MSG_LEN(32), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start_chk(start_s), .chk_q(q_s),
        .chk_address(addr_s), .busy(busy_s), .finish_chk(fin_s),
        .key_valid(kv_s), .key_invalid(ki_s),
        .bad_index(bi_s), .bad_byte(bb_s)
    );

    decrypted_msg_checker #(.MSG_LEN(256), .ADDR_W(8)) dut_big (
        .clk(clk), .reset(reset), .start_chk(start_b), .chk_q(q_b),
        .chk_address(addr_b), .busy(busy_b), .finish_chk(fin_b),
        .key_valid(kv_b), .key_invalid(ki_b),
        .bad_index(bi_b), .bad_byte(bb_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Registered RAM: data appears one cycle after the address.
    always @(posedge clk) begin
        q_s <= ram[addr_s];
        q_b <= ram[addr_b];
    end

    // Outcome model: at acceptance, scan the message for the first bad
    // byte, then derive every later cycle from the elapsed edge count.
    int len [2] = '{32, 256};
    bit act [2];
    int n [2], dd [2], last [2], bk [2], bv [2];
    bit good [2];
    int e_busy [2], e_fin [2], e_kv [2], e_ki [2];
    int e_addr [2], e_bi [2], e_bb [2];

    function automatic bit plain(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic st;
            st = (i == 0) ? start_s : start_b;
            if (reset) begin
                act[i] = 0;
                e_busy[i] = 0; e_fin[i] = 0; e_kv[i] = 0; e_ki[i] = 0;
                e_addr[i] = 0; e_bi[i] = 0; e_bb[i] = 0;
            end else if (act[i]) begin
                n[i]++;
                e_fin[i] = (n[i] == dd[i]) ? 1 : 0;
                if (n[i] > dd[i]) begin
                    act[i] = 0;
                    e_busy[i] = 0;
                end else begin
                    e_addr[i] = (n[i] / 2 < last[i]) ? n[i] / 2 : last[i];
                    if (n[i] == dd[i]) begin
                        e_kv[i] = good[i] ? 1 : 0;
                        e_ki[i] = good[i] ? 0 : 1;
                        e_bi[i] = good[i] ? 0 : bk[i];
                        e_bb[i] = good[i] ? 0 : bv[i];
                    end
                end
            end else if (st) begin
                bk[i] = -1;
                for (int j = 0; j < len[i]; j++) begin
                    if (bk[i] < 0 && !plain(ram[j])) begin
                        bk[i] = j;
                        bv[i] = int'(ram[j]);
                    end
                end
                good[i] = (bk[i] < 0);
                last[i] = good[i] ? len[i] - 1 : bk[i];
                dd[i]   = good[i] ? 2 * len[i] : 2 * bk[i] + 2;
                act[i] = 1; n[i] = 0;
                e_busy[i] = 1; e_fin[i] = 0; e_kv[i] = 0; e_ki[i] = 0;
                e_addr[i] = 0; e_bi[i] = 0; e_bb[i] = 0;
            end else begin
                e_fin[i] = 0;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("s.busy", int'(busy_s), e_busy[0]);
            chk("s.finish", int'(fin_s), e_fin[0]);
            chk("s.key_valid", int'(kv_s), e_kv[0]);
            chk("s.key_invalid", int'(ki_s), e_ki[0]);
            chk("s.address", int'(addr_s), e_addr[0]);
            chk("s.bad_index", int'(bi_s), e_bi[0]);
            chk("s.bad_byte", int'(bb_s), e_bb[0]);
            chk("b.busy", int'(busy_b), e_busy[1]);
            chk("b.finish", int'(fin_b), e_fin[1]);
            chk("b.key_valid", int'(kv_b), e_kv[1]);
            chk("b.key_invalid", int'(ki_b), e_ki[1]);
            chk("b.address", int'(addr_b), e_addr[1]);
            chk("b.bad_index", int'(bi_b), e_bi[1]);
            chk("b.bad_byte", int'(bb_b), e_bb[1]);
        end
    end

    task automatic fill_hello();
        string s;
        s = "hello world abcdefghijklmnopqrst";
        for (int i = 0; i < 32; i++) ram[i] = s[i];
    endtask

    task automatic pulse(input bit big);
        @(posedge clk); #1;
        if (big) start_b = 1; else start_s = 1;
        @(posedge clk); #1;
        start_b = 0;
        start_s = 0;
    endtask

    // Counts edges until finish_chk is seen; bounded.
    task automatic wait_fin(input bit big, output int cyc, output int maxa);
        int a;
        logic f;
        cyc = 0;
        maxa = int'(big ? addr_b : addr_s);
        f = 0;
        while (!f && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            a = int'(big ? addr_b : addr_s);
            if (a > maxa) maxa = a;
            f = big ? fin_b : fin_s;
        end
        if (!f) chk("finish_timeout", 0, 1);
    endtask

    task automatic run(input bit big, output int cycle, output int maxa);
        int c;
        pulse(big);
        wait_fin(big, c, maxa);
        cycle = c + 1;
    endtask

    logic [7:0] bvals [6] = '{8'h60, 8'h61, 8'h7A, 8'h7B, 8'h20, 8'h21};
    int cyc, maxa, j;
    bit ok;

    initial begin
        reset = 1; start_s = 0; start_b = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h20;
        fill_hello();
        repeat (2) @(posedge clk);
        chk_on = 1;
        #1 reset = 0;
        chk("rst_busy", int'(busy_s), 0);
        chk("rst_addr", int'(addr_s), 0);
        chk("rst_kv", int'(kv_s), 0);

        run(0, cyc, maxa);
        chk("valid_cycle", cyc, 65);
        chk("valid_kv", int'(kv_s), 1);
        chk("valid_ki", int'(ki_s), 0);
        chk("valid_maxaddr", maxa, 31);

        ram[5] = 8'h41;
        run(0, cyc, maxa);
        chk("bad5_cycle", cyc, 13);
        chk("bad5_ki", int'(ki_s), 1);
        chk("bad5_index", int'(bi_s), 5);
        chk("bad5_byte", int'(bb_s), 8'h41);
        chk("bad5_maxaddr", maxa, 5);
        fill_hello();

        for (int v = 0; v < 6; v++) begin
            j = v % 4;
            ram[j] = bvals[v];
            ok = (bvals[v] == 8'h61 || bvals[v] == 8'h7A || bvals[v] == 8'h20);
            run(0, cyc, maxa);
            chk("bnd_cycle", cyc, ok ? 65 : 2 * j + 3);
            chk("bnd_kv", int'(kv_s), ok ? 1 : 0);
            chk("bnd_index", int'(bi_s), ok ? 0 : j);
            chk("bnd_byte", int'(bb_s), ok ? 0 : int'(bvals[v]));
            fill_hello();
        end

        for (int i = 0; i < 256; i++) ram[i] = 8'h20;
        run(1, cyc, maxa);
        chk("big_cycle", cyc, 513);
        chk("big_kv", int'(kv_b), 1);
        chk("big_maxaddr", maxa, 255);
        chk("big_lastaddr", int'(addr_b), 255);
        fill_hello();

        pulse(0);
        repeat (21) @(posedge clk);
        #1;
        chk("mid_addr", int'(addr_s), 10);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("mid_rst_busy", int'(busy_s), 0);
        chk("mid_rst_addr", int'(addr_s), 0);
        chk("mid_rst_kv", int'(kv_s) | int'(ki_s), 0);
        run(0, cyc, maxa);
        chk("post_rst_kv", int'(kv_s), 1);

        pulse(0);
        repeat (10) @(posedge clk);
        #1 start_s = 1;
        @(posedge clk); #1 start_s = 0;
        wait_fin(0, cyc, maxa);
        chk("ignored_start_cyc", cyc, 53);
        chk("ignored_start_kv", int'(kv_s), 1);
        @(posedge clk); #1;
        chk("idle_after", int'(busy_s), 0);

        start_s = 1;
        wait_fin(0, cyc, maxa);
        chk("b2b1_kv", int'(kv_s), 1);
        ram[0] = 8'h00;
        @(posedge clk); #1;
        chk("b2b_hold_kv", int'(kv_s), 1);
        @(posedge clk); #1;
        chk("b2b_accept_busy", int'(busy_s), 1);
        chk("b2b_accept_kv", int'(kv_s), 0);
        start_s = 0;
        wait_fin(0, cyc, maxa);
        chk("b2b2_cycle", cyc + 1, 3);
        chk("b2b2_ki", int'(ki_s), 1);
        chk("b2b2_index", int'(bi_s), 0);
        chk("b2b2_byte", int'(bb_s), 0);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
